fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the decode/execute datapath. It owns the program counter, issues word reads to the synchronous instruction memory (one-cycle read latency), and buffers returned words in a small prefetch FIFO. Words are presented to decode through a valid/ready handshake. A redirect input flushes the stage and restarts fetch at a new address.

## Interface
- ADDR_W, 8: instruction memory byte-address width; IMEM_ADDR = PC[ADDR_W-1:0]
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2
- CLK  in  1  sole clock; all state on rising edge
- RST  in  1  asynchronous, active-low reset
- IMEM_EN  out  1  read strobe to instruction memory
- IMEM_ADDR  out  ADDR_W  byte address of the read; word-aligned
- IMEM_DATA  in  32  read data; valid the cycle after IMEM_EN=1
- INST  out  32  instruction word at FIFO head
- INST_PC  out  32  full PC of INST
- INST_VALID  out  1  FIFO non-empty
- INST_READY  in  1  decode accepts; transfer when VALID&READY at a rising edge
- REDIRECT  in  1  flush and restart fetch
- REDIRECT_PC  in  32  new fetch PC; bits [1:0] ignored, forced 0
- STALL_CNT  out  16  present only with FETCH_STALL_CNT_EN

## Operation
- State: fetch PC (32 b), in-flight flag plus its PC, FIFO of {word, PC}, occupancy count (0..DEPTH).
- Issue rule: IMEM_EN=1 when REDIRECT=0 and count + inflight < DEPTH. Count is the pre-edge value; a same-cycle pop does not free a credit. On issue, PC <= PC + 4.
- Response: if inflight=1 and no flush, IMEM_DATA and its PC are pushed at the next edge. Capacity is never exceeded by construction.
- Pop: a VALID&READY transfer advances the head. Push and pop in the same cycle keep count unchanged.
- Redirect, cycle with REDIRECT=1:
  - a handshake in that cycle completes normally;
  - at the edge: FIFO emptied, count=0, inflight=0, and the arriving response is discarded;
  - PC <= {REDIRECT_PC[31:2],2'b00};
  - IMEM_EN=0 in that cycle.
- Wrap-around:
  - PC wraps modulo 2^32.
  - IMEM_ADDR wraps modulo 2^ADDR_W, so PC 0xFC → 0x100 gives IMEM_ADDR 0xFC → 0x00 for ADDR_W=8.
  - INST_PC carries the full 32-bit PC.
  - FIFO pointers wrap modulo DEPTH.
- Reset (asynchronous assert, any time):
  - PC=0, FIFO empty, inflight=0;
  - a response arriving after reset releases is ignored.

## Timing
- Reset values: IMEM_EN=0, IMEM_ADDR=0, INST=0, INST_PC=0, INST_VALID=0, STALL_CNT=0.
- First cycle after release: IMEM_EN=1, IMEM_ADDR=0. Word 0 is pushed at the end of the next cycle, and INST_VALID=1 the cycle after that. Latency is 2 cycles from issue to valid.
- Sustained throughput is 1 word/cycle with READY held high (DEPTH ≥ 3).
- After REDIRECT at cycle n:
  - IMEM_EN=1 with the new address at n+1;
  - INST_VALID=0 at n+1 and n+2;
  - the new word is valid at n+3.
- INST/INST_PC are driven from the FIFO head register, with no combinational path from IMEM_DATA.
- INST_VALID does not depend on INST_READY in the same cycle.

## Configuration
- FETCH_STALL_CNT_EN defined:
  - STALL_CNT port exists: a 16-bit saturating counter (holds at 0xFFFF).
  - Increments each cycle with INST_VALID=0 and reset released.
  - Cleared only by RST, not by REDIRECT.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset release, READY=1, memory word = address: INST_VALID rises on cycle 2; INST/INST_PC sequence 0x00, 0x04, 0x08… at one per cycle.
- READY=0 for 10 cycles after first valid: count reaches DEPTH=4, IMEM_EN drops, INST holds word 0x00. Then READY=1: PCs 0x00..0x0C drain in order, then 0x10 follows without gap or duplicate.
- REDIRECT with REDIRECT_PC=0x43 while FIFO holds 3 entries and one read is in flight: next issued IMEM_ADDR is 0x40. No old word appears; first INST_PC=0x40 valid 3 cycles after redirect.
- Fetch across PC 0xFC: IMEM_ADDR 0xFC then 0x00; INST_PC 0xFC then 0x100.
- Assert RST mid-stream with a read in flight: outputs go to reset values immediately; after release the first INST_PC is 0x00 and no stale word is emitted.
- With FETCH_STALL_CNT_EN: STALL_CNT=2 after the initial fill; +2 per redirect; saturates at 0xFFFF under a forced-empty stall of 70000 cycles.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, decode-side instruction
// handshake and redirect request, bundled for the fetch_unit boundary.
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  // Instruction memory: synchronous read, data returns the cycle after IMEM_EN.
  logic              IMEM_EN;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [31:0]       IMEM_DATA;

  // Decode handshake: a word moves on a rising edge where INST_VALID and
  // INST_READY are both high; INST_VALID never waits on INST_READY, and
  // INST/INST_PC stay stable while INST_VALID is high and not accepted.
  logic [31:0]       INST;
  logic [31:0]       INST_PC;
  logic              INST_VALID;
  logic              INST_READY;

  // Redirect: flush everything fetched so far and restart at REDIRECT_PC.
  logic              REDIRECT;
  logic [31:0]       REDIRECT_PC;

  modport master (
    output IMEM_EN, IMEM_ADDR, INST, INST_PC, INST_VALID,
    input  IMEM_DATA, INST_READY, REDIRECT, REDIRECT_PC
  );

  modport slave (
    input  IMEM_EN, IMEM_ADDR, INST, INST_PC, INST_VALID,
    output IMEM_DATA, INST_READY, REDIRECT, REDIRECT_PC
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-deep read tracking and a prefetch FIFO.
// Optional FETCH_STALL_CNT_EN adds a saturating empty-cycle counter (STALL_CNT).
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]  STALL_CNT
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [31:0]      word_q [DEPTH];
  logic [31:0]      word_d [DEPTH];
  logic [31:0]      wpc_q  [DEPTH];
  logic [31:0]      wpc_d  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic             inst_valid;
  logic [CNT_W:0]   occupancy;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.REDIRECT_PC[1:0];

  assign inst_valid = (count_q != '0);
  // Credits count the in-flight read; a pop this cycle frees nothing until the edge.
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue      = RST && !bus.REDIRECT && (occupancy < DEPTH_C);
  assign push       = inflight_q && !bus.REDIRECT;
  assign pop        = inst_valid && bus.INST_READY;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    word_d        = word_q;
    wpc_d         = wpc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (bus.REDIRECT) begin
      pc_d       = {bus.REDIRECT_PC[31:2], 2'b00};
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end

      if (push) begin
        word_d[wr_ptr_q] = bus.IMEM_DATA;
        wpc_d[wr_ptr_q]  = inflight_pc_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      word_q        <= word_d;
      wpc_q         <= wpc_d;
    end
  end

  // Decode sees only registered FIFO storage, never IMEM_DATA directly.
  assign bus.INST       = word_q[rd_ptr_q];
  assign bus.INST_PC    = wpc_q[rd_ptr_q];
  assign bus.INST_VALID = inst_valid;
  assign bus.IMEM_EN    = issue;
  assign bus.IMEM_ADDR  = pc_q[ADDR_W-1:0];

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts starved decode cycles; survives redirects, saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!inst_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, program-order scoreboard and
// directed plus randomized scenarios.
module tb_fetch_unit;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus();
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef FETCH_STALL_CNT_EN
    ,
    .STALL_CNT (STALL_CNT)
`endif
  );

  // Unique word per memory address so data and PC mix-ups are visible.
  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // Synchronous instruction memory, one-cycle latency.
  always @(posedge CLK) begin
    if (bus.IMEM_EN === 1'b1) bus.IMEM_DATA <= word_of(bus.IMEM_ADDR);
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  logic              o_en;
  logic [ADDR_W-1:0] o_addr;
  logic              o_valid;
  logic [31:0]       o_pc;
  logic [31:0]       o_inst;

  // Expected stream is program order from the last restart point.
  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic sample();
    o_en    = bus.IMEM_EN;
    o_addr  = bus.IMEM_ADDR;
    o_valid = bus.INST_VALID;
    o_pc    = bus.INST_PC;
    o_inst  = bus.INST;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
    logic [31:0] exp_pc;
    @(negedge CLK);
    bus.INST_READY  = ready;
    bus.REDIRECT    = redir;
    bus.REDIRECT_PC = rpc;
    #1;
    sample();
    if (o_valid && ready) begin
      exp_pc = exp_q.pop_front();
      exp_q.push_back(exp_q[$] + 32'd4);
      xfers++;
      checks++;
      if (o_pc !== exp_pc || o_inst !== word_of(exp_pc[ADDR_W-1:0])) begin
        failures++;
        $display("FAIL scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h",
                 o_pc, o_inst, exp_pc, word_of(exp_pc[ADDR_W-1:0]));
      end
    end
    if (redir) sb_restart(rpc & ~32'h3);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST             = 1'b0;
    bus.INST_READY  = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = '0;
    #1;
    sample();
  endtask

  // Leaves the bench observing cycle 0 after release.
  task automatic release_reset(input logic ready);
    @(negedge CLK);
    bus.INST_READY = ready;
    RST = 1'b1;
    sb_restart(32'h0);
    #1;
    sample();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int gaps;
    apply_reset();
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL reset_imem_en: got %b expected 0", o_en); end
    checks++; if (o_addr !== '0) begin failures++; $display("FAIL reset_imem_addr: got %h expected 00", o_addr); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_inst !== 32'h0 || o_pc !== 32'h0) begin failures++; $display("FAIL reset_inst: got inst=%h pc=%h expected 0/0", o_inst, o_pc); end
`ifdef FETCH_STALL_CNT_EN
    checks++; if (STALL_CNT !== 16'h0) begin failures++; $display("FAIL reset_stall_cnt: got %h expected 0000", STALL_CNT); end
`endif
    release_reset(1'b1);
    checks++; if (o_en !== 1'b1 || o_addr !== '0) begin failures++; $display("FAIL first_issue: got en=%b addr=%h expected 1/00", o_en, o_addr); end
    step(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL latency_c1: got valid=%b expected 0", o_valid); end
    step(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin failures++; $display("FAIL latency_c2: got valid=%b pc=%h expected 1/0", o_valid, o_pc); end
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, '0);
      if (!o_valid) gaps++;
    end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL throughput: got %0d empty cycles expected 0", gaps); end
  endtask

  task automatic test_backpressure();
    int issues;
    int gaps;
    int x0;
    apply_reset();
    release_reset(1'b0);
    issues = o_en ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0);
      if (o_en) issues++;
    end
    checks++; if (issues !== DEPTH) begin failures++; $display("FAIL bp_issue_count: got %0d expected %0d", issues, DEPTH); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL bp_en_drop: got %b expected 0", o_en); end
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_inst !== word_of(8'h00)) begin
      failures++; $display("FAIL bp_hold_head: got valid=%b pc=%h inst=%h expected 1/0/%h", o_valid, o_pc, o_inst, word_of(8'h00));
    end
    gaps = 0;
    x0 = xfers;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0);
      if (!o_valid) gaps++;
    end
    checks++; if (gaps !== 0 || xfers - x0 !== 10) begin
      failures++; $display("FAIL bp_drain: got gaps=%0d xfers=%0d expected 0/10", gaps, xfers - x0);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    release_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    checks++; if (o_en !== 1'b1 || o_addr !== 8'h0C) begin failures++; $display("FAIL redir_pre: got en=%b addr=%h expected 1/0c", o_en, o_addr); end
    step(1'b0, 1'b1, 32'h43);
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL redir_en_n: got %b expected 0", o_en); end
    step(1'b1, 1'b0, '0);
    checks++; if (o_en !== 1'b1 || o_addr !== 8'h40 || o_valid !== 1'b0) begin
      failures++; $display("FAIL redir_n1: got en=%b addr=%h valid=%b expected 1/40/0", o_en, o_addr, o_valid);
    end
    step(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL redir_n2: got valid=%b expected 0", o_valid); end
    step(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40) begin failures++; $display("FAIL redir_n3: got valid=%b pc=%h expected 1/40", o_valid, o_pc); end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] addr_seq [3];
    logic [31:0] pc_seq [3];
    logic [ADDR_W-1:0] exp_addr [3];
    logic [31:0] exp_pc [3];
    exp_addr[0] = 8'hF8; exp_addr[1] = 8'hFC; exp_addr[2] = 8'h00;
    exp_pc[0] = 32'hF8;  exp_pc[1] = 32'hFC;  exp_pc[2] = 32'h100;
    apply_reset();
    release_reset(1'b0);
    step(1'b0, 1'b1, 32'hF8);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      if (i < 3) addr_seq[i] = o_addr;
      if (i >= 2) pc_seq[i-2] = o_pc;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (addr_seq[i] !== exp_addr[i]) begin failures++; $display("FAIL wrap_addr%0d: got %h expected %h", i, addr_seq[i], exp_addr[i]); end
      checks++; if (pc_seq[i] !== exp_pc[i]) begin failures++; $display("FAIL wrap_pc%0d: got %h expected %h", i, pc_seq[i], exp_pc[i]); end
    end
    // Full 32-bit PC wrap, with misaligned low bits that must be dropped.
    step(1'b1, 1'b1, 32'hFFFF_FFF9);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    checks++; if (o_pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc32: got %h expected 00000000", o_pc); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    release_reset(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    sample();
    checks++; if (o_en !== 1'b0 || o_addr !== '0 || o_valid !== 1'b0 || o_inst !== 32'h0 || o_pc !== 32'h0) begin
      failures++; $display("FAIL midreset_outputs: got en=%b addr=%h valid=%b inst=%h pc=%h expected all 0",
                           o_en, o_addr, o_valid, o_inst, o_pc);
    end
    release_reset(1'b1);
    step(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_stale: got valid=%b expected 0", o_valid); end
    step(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin failures++; $display("FAIL midreset_first: got valid=%b pc=%h expected 1/0", o_valid, o_pc); end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic test_random();
    int since;
    int x0;
    logic ready, redir;
    logic [31:0] rpc;
    apply_reset();
    release_reset(1'b0);
    since = 100;
    x0 = xfers;
    for (int i = 0; i < 800; i++) begin
      ready = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 99) < 4);
      rpc   = $urandom;
      since++;
      step(ready, redir, rpc);
      if (redir) begin
        checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL rand_redir_en: got %b expected 0", o_en); end
      end
      if (since == 1 || since == 2) begin
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rand_flush_gap: got valid=%b expected 0 at +%0d", o_valid, since); end
      end else if (since == 3) begin
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL rand_restart: got valid=%b expected 1 at +3", o_valid); end
      end
      if (redir) since = 0;
    end
    checks++; if (xfers - x0 < 100) begin failures++; $display("FAIL rand_progress: got %0d transfers expected >=100", xfers - x0); end
  endtask

`ifdef FETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    release_reset(1'b0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    checks++; if (STALL_CNT !== 16'd2) begin failures++; $display("FAIL stall_fill: got %0d expected 2", STALL_CNT); end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    checks++; if (STALL_CNT !== 16'd4) begin failures++; $display("FAIL stall_redirect: got %0d expected 4", STALL_CNT); end
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 32'h80);
    checks++; if (STALL_CNT !== 16'hFFFF) begin failures++; $display("FAIL stall_saturate: got %h expected ffff", STALL_CNT); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.INST_READY  = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = '0;
    repeat (2) @(posedge CLK);
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
`ifdef FETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
